// File: rtl/arbiter_pkg.sv
// Shared constants for the weighted round-robin arbiter: FSM state encoding
// and the credit value a zero weight is promoted to.
package arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_WEIGHT = 1;

endpackage

// File: rtl/priority_encoder.sv
// Fixed-priority encoder: returns the index of the winning set bit.
// LSB_HIGH_PRIORITY=1 picks the lowest set index, 0 picks the highest.
module priority_encoder #(
    parameter int WIDTH             = 4,
    parameter int LSB_HIGH_PRIORITY = 0
) (
    input  logic [WIDTH-1:0]         req,
    output logic                     valid,
    output logic [$clog2(WIDTH)-1:0] index
);

    localparam int IDX_W = $clog2(WIDTH);

    always_comb begin
        valid = |req;
        index = '0;
        // Scan so the preferred end is visited last and overwrites the others.
        if (LSB_HIGH_PRIORITY != 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (req[i]) index = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (req[i]) index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter with blocking, per-port credit-limited grants.
// Optional feature: define ARBITER_WRR_LOCK_EN to add a lock input that pins the grant.
module arbiter_wrr
    import arbiter_pkg::*;
#(
    parameter int PORTS             = 4,
    parameter int WEIGHT_W          = 4,
    parameter int LSB_HIGH_PRIORITY = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PORTS-1:0]          request,
    input  logic [PORTS-1:0]          acknowledge,
    input  logic [PORTS*WEIGHT_W-1:0] weight,
`ifdef ARBITER_WRR_LOCK_EN
    input  logic [PORTS-1:0]          lock,
`endif
    output logic [PORTS-1:0]          grant,
    output logic                      grant_valid,
    output logic [$clog2(PORTS)-1:0]  grant_encoded,
    output logic [WEIGHT_W-1:0]       credit
);

    localparam int IDX_W = $clog2(PORTS);

    state_t              state_q, state_d;
    logic [PORTS-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    grant_encoded_q, grant_encoded_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic                ptr_vld_q, ptr_vld_d;

    logic [PORTS-1:0]    req_mask;
    logic [PORTS-1:0]    req_masked;
    logic                masked_vld;
    logic [IDX_W-1:0]    masked_idx;
    logic                any_req;
    logic [IDX_W-1:0]    full_idx;
    logic [IDX_W-1:0]    winner;
    logic [WEIGHT_W-1:0] winner_weight;
    logic [WEIGHT_W-1:0] load_credit;
    logic                ack_p;
    logic                req_p;
    logic                keep_lock;
    logic                rearb;

    // Candidates lie strictly past the last granted index in the priority
    // direction; before any grant the whole vector is eligible.
    always_comb begin
        req_mask = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (!ptr_vld_q) begin
                req_mask[i] = 1'b1;
            end else if (LSB_HIGH_PRIORITY != 0) begin
                req_mask[i] = (IDX_W'(i) > ptr_q);
            end else begin
                req_mask[i] = (IDX_W'(i) < ptr_q);
            end
        end
    end

    assign req_masked = request & req_mask;

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
    ) u_pe_masked (
        .req   (req_masked),
        .valid (masked_vld),
        .index (masked_idx)
    );

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
    ) u_pe_full (
        .req   (request),
        .valid (any_req),
        .index (full_idx)
    );

    assign winner        = masked_vld ? masked_idx : full_idx;
    assign winner_weight = weight[int'(winner)*WEIGHT_W +: WEIGHT_W];
    assign load_credit   = (winner_weight == '0) ? WEIGHT_W'(DEFAULT_WEIGHT) : winner_weight;

    assign ack_p = acknowledge[grant_encoded_q];
    assign req_p = request[grant_encoded_q];

`ifdef ARBITER_WRR_LOCK_EN
    assign keep_lock = lock[grant_encoded_q];
`else
    assign keep_lock = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        grant_encoded_d = grant_encoded_q;
        credit_d        = credit_q;
        ptr_d           = ptr_q;
        ptr_vld_d       = ptr_vld_q;
        rearb           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rearb = any_req;
            end
            ST_GRANT: begin
                if (ack_p && !keep_lock) begin
                    if (req_p && (credit_q > WEIGHT_W'(1))) begin
                        credit_d = credit_q - WEIGHT_W'(1);
                    end else begin
                        rearb = 1'b1;
                    end
                end
            end
            default: begin
                rearb = 1'b1;
            end
        endcase

        // Re-arbitration lands the next winner directly, so no idle cycle appears.
        if (rearb) begin
            if (any_req) begin
                state_d          = ST_GRANT;
                grant_d          = '0;
                grant_d[winner]  = 1'b1;
                grant_encoded_d  = winner;
                credit_d         = load_credit;
                ptr_d            = winner;
                ptr_vld_d        = 1'b1;
            end else begin
                state_d          = ST_IDLE;
                grant_d          = '0;
                grant_encoded_d  = '0;
                credit_d         = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            grant_q         <= '0;
            grant_encoded_q <= '0;
            credit_q        <= '0;
            ptr_q           <= '0;
            ptr_vld_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            grant_encoded_q <= grant_encoded_d;
            credit_q        <= credit_d;
            ptr_q           <= ptr_d;
            ptr_vld_q       <= ptr_vld_d;
        end
    end

    assign grant         = grant_q;
    assign grant_valid   = (state_q == ST_GRANT);
    assign grant_encoded = grant_encoded_q;
    assign credit        = credit_q;

endmodule
